// File: rtl/frame_writer.sv
// ============================================================================
// Module  : frame_writer
// Brief   : Sprite blitter copying a ROM sprite into a 640x480 frame buffer,
//           clipping off-screen pixels. Optional macro:
//           FRAME_WRITER_TRANSPARENCY_EN (suppress TRANSPARENT_CODE pixels).
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_writer #(
    parameter int                SCREEN_W         = 640,
    parameter int                SCREEN_H         = 480,
    parameter int                ADDR_W           = 19,
    parameter int                PIX_W            = 8,
    parameter int                SPR_ADDR_W       = 12,
    parameter int                DIM_W            = 7,
    parameter logic [PIX_W-1:0]  TRANSPARENT_CODE = 8'h00
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [10:0]           dst_x,
    input  logic [10:0]           dst_y,
    input  logic [DIM_W-1:0]      spr_w,
    input  logic [DIM_W-1:0]      spr_h,
    input  logic [SPR_ADDR_W-1:0] spr_base,
    output logic [SPR_ADDR_W-1:0] spr_rdAddress,
    input  logic [PIX_W-1:0]      spr_data,
    output logic [ADDR_W-1:0]     frame_wrAddress,
    output logic [PIX_W-1:0]      frame_input,
    output logic                  frame_we,
    output logic                  busy,
    output logic                  done
);

    localparam int                     RB_W        = 22;
    localparam logic signed [11:0]     C_SCR_W     = 12'(SCREEN_W);
    localparam logic signed [11:0]     C_SCR_H     = 12'(SCREEN_H);
    localparam logic signed [RB_W-1:0] C_STRIDE    = RB_W'(SCREEN_W);
    localparam logic [RB_W-1:0]        C_FRAME_PIX = RB_W'(SCREEN_W * SCREEN_H);
`ifdef FRAME_WRITER_TRANSPARENCY_EN
    localparam logic                   C_TRANSP_EN = 1'b1;
`else
    localparam logic                   C_TRANSP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [10:0]             r_dst_x;
    logic [10:0]             r_dst_y;
    logic [DIM_W-1:0]        r_w;
    logic [DIM_W-1:0]        r_h;
    logic [SPR_ADDR_W-1:0]   r_base;
    logic [SPR_ADDR_W-1:0]   r_ptr;
    logic [DIM_W-1:0]        r_col;
    logic [DIM_W-1:0]        r_row;
    logic signed [RB_W-1:0]  r_rowbase;
    logic                    r_vis;
    logic [ADDR_W-1:0]       r_addr;

    logic signed [RB_W-1:0]  w_y_ext;
    logic signed [RB_W-1:0]  w_setup_rowbase;
    logic signed [11:0]      w_px;
    logic signed [11:0]      w_py;
    logic signed [RB_W-1:0]  w_addr_full;
    logic                    w_vis;
    logic                    w_col_last;
    logic                    w_last;
    logic                    w_wr_phase;
    logic                    w_we;

    // Row base = y*640 built from shifts so no multiplier is needed.
    assign w_y_ext         = {{(RB_W-11){r_dst_y[10]}}, r_dst_y};
    assign w_setup_rowbase = (w_y_ext <<< 9) + (w_y_ext <<< 7);

    assign w_px        = {r_dst_x[10], r_dst_x} + {5'd0, r_col};
    assign w_py        = {r_dst_y[10], r_dst_y} + {5'd0, r_row};
    assign w_addr_full = r_rowbase + {{(RB_W-12){w_px[11]}}, w_px};
    assign w_vis       = !w_px[11] && (w_px < C_SCR_W) &&
                         !w_py[11] && (w_py < C_SCR_H) &&
                         ($unsigned(w_addr_full) < C_FRAME_PIX);

    assign w_col_last = (r_col == r_w - DIM_W'(1));
    assign w_last     = w_col_last && (r_row == r_h - DIM_W'(1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SETUP;
            S_SETUP: w_next = ((r_w == '0) || (r_h == '0)) ? S_DONE : S_RUN;
            S_RUN:   if (w_last) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_dst_x   <= '0;
            r_dst_y   <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_base    <= '0;
            r_ptr     <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_rowbase <= '0;
            r_vis     <= 1'b0;
            r_addr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dst_x <= dst_x;
                        r_dst_y <= dst_y;
                        r_w     <= spr_w;
                        r_h     <= spr_h;
                        r_base  <= spr_base;
                    end
                end
                S_SETUP: begin
                    r_col     <= '0;
                    r_row     <= '0;
                    r_ptr     <= r_base;
                    r_rowbase <= w_setup_rowbase;
                end
                S_RUN: begin
                    r_ptr <= r_ptr + SPR_ADDR_W'(1);
                    if (w_col_last) begin
                        r_col     <= '0;
                        r_row     <= r_row + DIM_W'(1);
                        r_rowbase <= r_rowbase + C_STRIDE;
                    end else begin
                        r_col <= r_col + DIM_W'(1);
                    end
                end
                default: ;
            endcase
            // Aligns the write with the ROM's one-cycle read latency.
            r_vis  <= (r_state == S_RUN) && w_vis;
            r_addr <= w_addr_full[ADDR_W-1:0];
        end
    end

    assign w_wr_phase = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign w_we       = r_vis && w_wr_phase &&
                        !(C_TRANSP_EN && (spr_data == TRANSPARENT_CODE));

    assign frame_we        = w_we;
    assign frame_wrAddress = w_we ? r_addr : '0;
    assign frame_input     = w_we ? spr_data : '0;
    assign spr_rdAddress   = (r_state == S_RUN) ? r_ptr : '0;
    assign busy            = (r_state == S_SETUP) || w_wr_phase;
    assign done            = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_frame_writer.sv
// ============================================================================
// Module  : tb_frame_writer
// Brief   : Directed vector bench for frame_writer with a ROM model and a
//           pixel-level reference of the expected write stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_writer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [10:0] dst_x;
    logic [10:0] dst_y;
    logic [6:0]  spr_w;
    logic [6:0]  spr_h;
    logic [11:0] spr_base;
    logic [11:0] spr_rdAddress;
    logic [7:0]  spr_data;
    logic [18:0] frame_wrAddress;
    logic [7:0]  frame_input;
    logic        frame_we;
    logic        busy;
    logic        done;

    frame_writer dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .start           (start),
        .dst_x           (dst_x),
        .dst_y           (dst_y),
        .spr_w           (spr_w),
        .spr_h           (spr_h),
        .spr_base        (spr_base),
        .spr_rdAddress   (spr_rdAddress),
        .spr_data        (spr_data),
        .frame_wrAddress (frame_wrAddress),
        .frame_input     (frame_input),
        .frame_we        (frame_we),
        .busy            (busy),
        .done            (done)
    );

    always #5 Clk = ~Clk;

    logic [7:0] rom [4096];
    always @(posedge Clk) spr_data <= rom[spr_rdAddress];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int dx, dy, w, h, base;
        int nwr, f_addr, f_data, f_cyc, l_addr, l_data, done_cyc;
    } vec_t;

    vec_t vecs [7];
    int   tests = 0;
    int   fails = 0;
    int   wa[$], wd[$], wc[$];
    int   ea[$], ed[$], ec[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build_model(input vec_t v);
        ea.delete(); ed.delete(); ec.delete();
        for (int r = 0; r < v.h; r++) begin
            for (int c = 0; c < v.w; c++) begin
                int k, x, y;
                logic [7:0] d;
                k = r * v.w + c;
                x = v.dx + c;
                y = v.dy + r;
                d = rom[(v.base + k) % 4096];
                if (x >= 0 && x < 640 && y >= 0 && y < 480) begin
`ifdef FRAME_WRITER_TRANSPARENCY_EN
                    if (d != 8'h00) begin
                        ea.push_back(y * 640 + x); ed.push_back(int'(d)); ec.push_back(3 + k);
                    end
`else
                    ea.push_back(y * 640 + x); ed.push_back(int'(d)); ec.push_back(3 + k);
`endif
                end
            end
        end
    endtask

    task automatic issue(input int dx, input int dy, input int w, input int h, input int base);
        dst_x    = 11'(dx);
        dst_y    = 11'(dy);
        spr_w    = 7'(w);
        spr_h    = 7'(h);
        spr_base = 12'(base);
        start    = 1'b1;
    endtask

    // Issues a command and records writes until done; returns on the done cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int rel, done_rel, busy_bad, n;
        @(negedge Clk);
        issue(v.dx, v.dy, v.w, v.h, v.base);
        @(negedge Clk);
        start = 1'b0;
        wa.delete(); wd.delete(); wc.delete();
        rel = 1; done_rel = -1; busy_bad = 0;
        while (rel <= 300) begin
            if (frame_we) begin
                wa.push_back(int'(frame_wrAddress)); wd.push_back(int'(frame_input)); wc.push_back(rel);
            end
            if (done) begin
                done_rel = rel;
                break;
            end
            if (!busy) busy_bad++;
            @(negedge Clk);
            rel++;
        end
        check($sformatf("v%0d done_cycle", idx), done_rel, v.done_cyc);
        check($sformatf("v%0d busy_at_done", idx), int'(busy), 0);
        check($sformatf("v%0d busy_gaps", idx), busy_bad, 0);
        check($sformatf("v%0d n_writes", idx), wa.size(), v.nwr);
        if (v.nwr > 0 && wa.size() > 0) begin
            check($sformatf("v%0d first_addr", idx), wa[0], v.f_addr);
            check($sformatf("v%0d first_data", idx), wd[0], v.f_data);
            check($sformatf("v%0d first_cycle", idx), wc[0], v.f_cyc);
            check($sformatf("v%0d last_addr", idx), wa[wa.size()-1], v.l_addr);
            check($sformatf("v%0d last_data", idx), wd[wd.size()-1], v.l_data);
        end
        build_model(v);
        check($sformatf("v%0d model_count", idx), wa.size(), ea.size());
        n = (wa.size() < ea.size()) ? wa.size() : ea.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("v%0d w%0d addr", idx, k), wa[k], ea[k]);
            check($sformatf("v%0d w%0d data", idx, k), wd[k], ed[k]);
            check($sformatf("v%0d w%0d cycle", idx, k), wc[k], ec[k]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " frame_we"}, int'(frame_we), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " wr_addr"}, int'(frame_wrAddress), 0);
        check({tag, " wr_data"}, int'(frame_input), 0);
        check({tag, " rd_addr"}, int'(spr_rdAddress), 0);
    endtask

    initial begin
        int n_done, n_wr;
        for (int i = 0; i < 4096; i++) rom[i] = 8'(i);
        rom[100] = 8'h05; rom[101] = 8'h00; rom[102] = 8'h07;

        //          dx   dy   w  h  base  nwr f_addr  f_d f_c l_addr  l_d done
        vecs[0] = '{10,  5,   4, 2, 0,    8,  3210,   0,  3,  3853,   7,  11};
        vecs[1] = '{-2,  0,   4, 1, 0,    2,  0,      2,  5,  1,      3,  7};
        vecs[2] = '{639, 479, 2, 2, 0,    1,  307199, 0,  3,  307199, 0,  7};
        vecs[3] = '{0,   0,   0, 5, 0,    0,  0,      0,  0,  0,      0,  2};
        vecs[4] = '{0,   0,   3, 1, 100,  3,  0,      5,  3,  2,      7,  6};
        vecs[5] = '{5,   -1,  2, 2, 4094, 2,  5,      0,  5,  6,      1,  7};
        vecs[6] = '{638, 10,  4, 1, 8,    2,  7038,   8,  3,  7039,   9,  7};

        Reset = 1'b1;
        issue(0, 0, 0, 0, 0);
        start = 1'b0;
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Start during the done cycle must be ignored.
        issue(0, 0, 1, 1, 0);
        @(negedge Clk);
        start = 1'b0;
        check("start_in_done busy1", int'(busy), 0);
        @(negedge Clk);
        check("start_in_done busy2", int'(busy), 0);

        // Start pulse while busy must not spawn a second command.
        issue(0, 0, 2, 2, 0);
        @(negedge Clk);
        start = 1'b0;
        n_done = 0; n_wr = 0;
        for (int r = 1; r <= 30; r++) begin
            if (frame_we) n_wr++;
            if (done) n_done++;
            if (r == 3) issue(100, 100, 3, 3, 0);
            else start = 1'b0;
            @(negedge Clk);
        end
        start = 1'b0;
        check("busy_start done_pulses", n_done, 1);
        check("busy_start writes", n_wr, 4);

        // Asynchronous reset in the middle of a 4x4 blit.
        issue(0, 0, 4, 4, 0);
        @(negedge Clk);
        start = 1'b0;
        repeat (5) @(negedge Clk);
        check("midrun we_before_reset", int'(frame_we), 1);
        #2 Reset = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        @(negedge Clk);
        Reset = 1'b0;
        n_done = 0; n_wr = 0;
        for (int r = 0; r < 30; r++) begin
            if (frame_we) n_wr++;
            if (done) n_done++;
            @(negedge Clk);
        end
        check("after_reset done_pulses", n_done, 0);
        check("after_reset writes", n_wr, 0);

        run_vec(vecs[0], 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
